// File: rtl/corr_pkg.sv
// =============================================================================
// corr_pkg : shared widths and FSM state encoding for the correlator back end
// Revision : 1.0
// =============================================================================
`default_nettype none

package corr_pkg;

  localparam int CORR_IN_W  = 20;
  localparam int CORR_STEPS = 64;
  localparam int CORR_ACC_W = 26;
  localparam int CORR_IDX_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } corr_state_t;

  // Step counter wide enough to run one bit past STEPS so long frames stay visible.
  function automatic int corr_cnt_w(input int steps);
    return $clog2(steps) + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/corr_result_fifo.sv
// =============================================================================
// corr_result_fifo : 2-entry result FIFO, valid/ready head, simultaneous push/pop
// Revision : 1.0
// =============================================================================
`default_nettype none

module corr_result_fifo #(
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             full
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  // When full, the slot being written is the one being popped this cycle.
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data  = r_mem[r_rd_ptr];
  assign pop_valid = (r_count != 2'd0);
  assign full      = (r_count == 2'd2);

endmodule

`default_nettype wire

// File: rtl/corr_accum_peak.sv
// =============================================================================
// corr_accum_peak : per-frame correlation accumulator with result FIFO, sticky
//                   error flags and optional peak/threshold tracking (CORR_PEAK_EN)
// Revision : 1.0
// =============================================================================
`default_nettype none

module corr_accum_peak
  import corr_pkg::*;
#(
  parameter int IN_W  = CORR_IN_W,
  parameter int ACC_W = CORR_ACC_W,
  parameter int STEPS = CORR_STEPS,
  parameter int IDX_W = CORR_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  corr_in,
  input  logic             corr_valid,
  input  logic             corr_first,
  input  logic             corr_last,
  input  logic [ACC_W-1:0] threshold,
  input  logic             clear_peak,
  input  logic             clear_err,
  output logic [ACC_W-1:0] result,
  output logic [IDX_W-1:0] result_idx,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             detect,
  output logic [ACC_W-1:0] peak_value,
  output logic [IDX_W-1:0] peak_idx,
  output logic             err_len,
  output logic             err_seq,
  output logic             err_ovf
);

  localparam int CNT_W = corr_cnt_w(STEPS);
  localparam int DAT_W = ACC_W + IDX_W;

  corr_state_t      r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_step_cnt;
  logic [IDX_W-1:0] r_frame_idx;
  logic             r_err_len;
  logic             r_err_seq;
  logic             r_err_ovf;

  logic             w_start;
  logic             w_cont;
  logic             w_stray;
  logic             w_restart;
  logic [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_emit;
  logic             w_len_bad;
  logic             w_full;
  logic             w_push_ok;
  logic             w_drop;
  logic [DAT_W-1:0] w_fifo_data;
  logic             w_fifo_valid;

  always_comb begin
    w_start    = corr_valid && corr_first;
    w_cont     = corr_valid && !corr_first && (r_state == ST_ACCUM);
    w_stray    = corr_valid && !corr_first && (r_state == ST_IDLE);
    w_restart  = w_start && (r_state == ST_ACCUM);
    w_sum      = w_start ? ACC_W'(corr_in) : (r_acc + ACC_W'(corr_in));
    if (w_start) begin
      w_cnt_next = CNT_W'(1);
    end else if (r_step_cnt == '1) begin
      w_cnt_next = r_step_cnt;
    end else begin
      w_cnt_next = r_step_cnt + CNT_W'(1);
    end
    w_emit     = (w_start || w_cont) && corr_last;
    w_len_bad  = w_emit && (w_cnt_next != CNT_W'(STEPS));
    w_push_ok  = w_emit && (!w_full || result_ready);
    w_drop     = w_emit && w_full && !result_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_step_cnt  <= '0;
      r_frame_idx <= '0;
      r_err_len   <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_start || w_cont) begin
        r_acc      <= w_sum;
        r_step_cnt <= w_cnt_next;
        r_state    <= corr_last ? ST_IDLE : ST_ACCUM;
      end
      // Dropped frames still consume an index so downstream can see the gap.
      if (w_emit) begin
        r_frame_idx <= r_frame_idx + IDX_W'(1);
      end
      r_err_len <= (r_err_len && !clear_err) || w_len_bad;
      r_err_seq <= (r_err_seq && !clear_err) || w_stray || w_restart;
      r_err_ovf <= (r_err_ovf && !clear_err) || w_drop;
    end
  end

  corr_result_fifo #(
    .WIDTH (DAT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_ok),
    .push_data ({w_sum, r_frame_idx}),
    .pop       (result_ready),
    .pop_data  (w_fifo_data),
    .pop_valid (w_fifo_valid),
    .full      (w_full)
  );

  assign result       = w_fifo_data[DAT_W-1:IDX_W];
  assign result_idx   = w_fifo_data[IDX_W-1:0];
  assign result_valid = w_fifo_valid;
  assign err_len      = r_err_len;
  assign err_seq      = r_err_seq;
  assign err_ovf      = r_err_ovf;

`ifdef CORR_PEAK_EN
  logic             r_detect;
  logic [ACC_W-1:0] r_peak_value;
  logic [IDX_W-1:0] r_peak_idx;
  logic [ACC_W-1:0] w_peak_base;

  // A clear in the same cycle as a push lets that push seed the new peak.
  assign w_peak_base = clear_peak ? '0 : r_peak_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_detect     <= 1'b0;
      r_peak_value <= '0;
      r_peak_idx   <= '0;
    end else begin
      r_detect <= w_push_ok && (w_sum >= threshold);
      if (w_push_ok && (w_sum > w_peak_base)) begin
        r_peak_value <= w_sum;
        r_peak_idx   <= r_frame_idx;
      end else if (clear_peak) begin
        r_peak_value <= '0;
        r_peak_idx   <= '0;
      end
    end
  end

  assign detect     = r_detect;
  assign peak_value = r_peak_value;
  assign peak_idx   = r_peak_idx;
`else
  logic w_unused;
  assign w_unused   = ^{threshold, clear_peak};
  assign detect     = 1'b0;
  assign peak_value = '0;
  assign peak_idx   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_corr_accum_peak.sv
// =============================================================================
// tb_corr_accum_peak : scoreboard bench for corr_accum_peak (CORR_PEAK_EN optional)
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_corr_accum_peak;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] corr_in = '0;
  logic        corr_valid = 1'b0;
  logic        corr_first = 1'b0;
  logic        corr_last = 1'b0;
  logic [25:0] threshold = '0;
  logic        clear_peak = 1'b0;
  logic        clear_err = 1'b0;
  logic [25:0] result;
  logic [15:0] result_idx;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        detect;
  logic [25:0] peak_value;
  logic [15:0] peak_idx;
  logic        err_len;
  logic        err_seq;
  logic        err_ovf;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [41:0] exp_q[$];
  logic [15:0] tb_idx = '0;

  always #5 clk = ~clk;

  corr_accum_peak dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .corr_in      (corr_in),
    .corr_valid   (corr_valid),
    .corr_first   (corr_first),
    .corr_last    (corr_last),
    .threshold    (threshold),
    .clear_peak   (clear_peak),
    .clear_err    (clear_err),
    .result       (result),
    .result_idx   (result_idx),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .detect       (detect),
    .peak_value   (peak_value),
    .peak_idx     (peak_idx),
    .err_len      (err_len),
    .err_seq      (err_seq),
    .err_ovf      (err_ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Monitor: every accepted FIFO head is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {38'd0, result}, 64'hFFFF_FFFF);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("result_sum", {38'd0, result}, {38'd0, e[41:16]});
        check("result_idx", {48'd0, result_idx}, {48'd0, e[15:0]});
      end
    end
  end

  task automatic expect_push(input int sum);
    exp_q.push_back({26'(sum), tb_idx});
    tb_idx++;
  endtask

  task automatic drive(input logic v, input logic f, input logic l, input int d);
    @(posedge clk);
    #1;
    corr_valid = v;
    corr_first = f;
    corr_last  = l;
    corr_in    = 20'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic run_frame(input int n, input int first_val, input int rest_val, input logic mark_last);
    for (int i = 0; i < n; i++)
      drive(1'b1, i == 0, mark_last && (i == n - 1), (i == 0) ? first_val : rest_val);
  endtask

  task automatic pulse_clear_err();
    @(posedge clk); #1 clear_err = 1'b1;
    @(posedge clk); #1 clear_err = 1'b0;
  endtask

  task automatic enter_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    corr_valid = 1'b0; corr_first = 1'b0; corr_last = 1'b0;
    exp_q.delete();
    tb_idx = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'd0, result_valid}, 0);
    check("rst_errs", {61'd0, err_len, err_seq, err_ovf}, 0);
    check("rst_result", {38'd0, result}, 0);
    #1 rst_n = 1'b1;

    // 1: nominal 64-beat frame, latency of one clock after the last beat
    result_ready = 1'b1;
    run_frame(64, 1000, 1000, 1'b1);
    expect_push(64000);
    @(negedge clk);
    check("t1_valid_before", {63'd0, result_valid}, 0);
    idle(1);
    @(negedge clk);
    check("t1_valid_after", {63'd0, result_valid}, 1);
    check("t1_err_len", {63'd0, err_len}, 0);
`ifndef CORR_PEAK_EN
    check("t1_detect_tied", {63'd0, detect}, 0);
    check("t1_peak_tied", {38'd0, peak_value}, 0);
`endif
    idle(3);

    // 2: back-to-back frames with consumer stalled, third is dropped
    enter_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    result_ready = 1'b0;
    run_frame(64, 1, 1, 1'b1); expect_push(64);
    run_frame(64, 2, 2, 1'b1); expect_push(128);
    run_frame(64, 3, 3, 1'b1); tb_idx++;
    idle(1);
    @(negedge clk);
    check("t2_err_ovf", {63'd0, err_ovf}, 1);
    check("t2_head_sum", {38'd0, result}, 64);
    check("t2_head_idx", {48'd0, result_idx}, 0);
    idle(5);
    @(negedge clk);
    check("t2_hold_sum", {38'd0, result}, 64);
    check("t2_hold_valid", {63'd0, result_valid}, 1);
    result_ready = 1'b1;
    idle(3);
    pulse_clear_err();
    @(negedge clk);
    check("t2_ovf_cleared", {63'd0, err_ovf}, 0);
    run_frame(64, 4, 4, 1'b1); expect_push(256);
    idle(3);

    // 3: short frame flags err_len but is still emitted
    run_frame(10, 7, 7, 1'b1); expect_push(70);
    idle(1);
    @(negedge clk);
    check("t3_err_len", {63'd0, err_len}, 1);
    idle(2);
    pulse_clear_err();
    @(negedge clk);
    check("t3_len_cleared", {63'd0, err_len}, 0);

    // 3b: push and pop together while full loses nothing
    result_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 11); expect_push(11);
    drive(1'b1, 1'b1, 1'b1, 22); expect_push(22);
    drive(1'b1, 1'b1, 1'b1, 33); expect_push(33);
    result_ready = 1'b1;
    idle(1);
    @(negedge clk);
    check("t3b_no_ovf", {63'd0, err_ovf}, 0);
    check("t3b_err_len", {63'd0, err_len}, 1);
    idle(4);
    pulse_clear_err();

    // 4: stray beats in IDLE, then a restart mid-frame
    drive(1'b1, 1'b0, 1'b0, 5);
    drive(1'b1, 1'b0, 1'b1, 5);
    idle(1);
    @(negedge clk);
    check("t4_err_seq", {63'd0, err_seq}, 1);
    check("t4_no_push", {63'd0, result_valid}, 0);
    pulse_clear_err();
    @(negedge clk);
    check("t4_seq_cleared", {63'd0, err_seq}, 0);
    run_frame(5, 10, 10, 1'b0);
    run_frame(64, 3, 3, 1'b1); expect_push(192);
    idle(1);
    @(negedge clk);
    check("t4_restart_seq", {63'd0, err_seq}, 1);
    check("t4_restart_len", {63'd0, err_len}, 0);
    idle(3);

`ifdef CORR_PEAK_EN
    // 5: threshold hits and peak tracking (frame indices 9..12 at this point)
    begin
      int sums[4];
      logic det_exp[4];
      sums = '{500, 900, 900, 300};
      det_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
      threshold = 26'd800;
      @(posedge clk); #1 clear_peak = 1'b1;
      @(posedge clk); #1 clear_peak = 1'b0;
      for (int k = 0; k < 4; k++) begin
        run_frame(64, sums[k], 0, 1'b1); expect_push(sums[k]);
        idle(1);
        @(negedge clk);
        check("t5_detect", {63'd0, detect}, {63'd0, det_exp[k]});
      end
      @(negedge clk);
      check("t5_peak_value", {38'd0, peak_value}, 900);
      check("t5_peak_idx", {48'd0, peak_idx}, 10);
      idle(3);
    end
`endif

    // 6: async reset mid-frame
    run_frame(30, 5, 5, 1'b0);
    enter_reset();
    @(negedge clk);
    check("t6_rst_valid", {63'd0, result_valid}, 0);
    check("t6_rst_result", {22'd0, result, result_idx}, 0);
    check("t6_rst_errs", {61'd0, err_len, err_seq, err_ovf}, 0);
    check("t6_rst_peak", {21'd0, detect, peak_value, peak_idx}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(64, 5, 5, 1'b1); expect_push(320);
    idle(1);
    @(negedge clk);
    check("t6_valid", {63'd0, result_valid}, 1);
    check("t6_err_seq", {63'd0, err_seq}, 0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("drain", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
